fsmd_seq: RTL and testbench
===========================

# fsmd_seq

Microcoded sequencer for the FSMD datapath (register file R0–R7, ALU, EXT/ALU write-back mux). It replaces hard-wired per-algorithm state machines: it steps a program counter through an external combinational micro-program ROM, decodes each micro-instruction into datapath controls, and branches on registered ALU flags. A start/done handshake lets a host launch a program, and a step watchdog aborts runaway programs.

## Interface
- Parameters:
  - START_ADDR, 0: program entry address (UPC_W bits).
  - MAX_STEPS, 255: RUN cycles allowed before abort; 1..2^16-1.
- Ports:
  - clk  in  1  clock.
  - srst  in  1  reset, synchronous, active-high.
  - start_in  in  1  launch request; sampled only in IDLE.
  - busy_out  out  1  high whenever the state is not IDLE.
  - done_out  out  1  one-cycle completion pulse.
  - err_out  out  1  one-cycle pulse, coincident with done_out, on abort.
  - pc_out  out  UPC_W  ROM address.
  - instr_in  in  uinstr_t  ROM data, combinational from pc_out in the same cycle.
  - n_in, z_in  in  1 each  ALU negative/zero flags for the current cycle.
  - we_out  out  1  register-file write enable.
  - rsel_out, asel_out, bsel_out  out  rsel_t  write, A and B register selects.
  - dsel_out  out  dsel_t  write-back source select.
  - fsel_out  out  alufunc_t  ALU function.

## Operation
- States: IDLE, RUN, DONE, ABORT.
- IDLE:
  - start_in=1 → RUN. Load pc=START_ADDR, step count=0, flags n_r=z_r=0.
  - Otherwise hold.
- RUN: decode instr_in.op (uop_t, 3 bits).
  - EXEC(0): drive we/rsel/asel/bsel/dsel/fsel from the instruction fields. Latch n_r<=n_in, z_r<=z_in. pc<=pc+1.
  - JMP(1): pc<=target.
  - BZ(2): pc<=z_r ? target : pc+1.
  - BN(3): pc<=n_r ? target : pc+1.
  - HALT(4): → DONE.
  - Reserved (5–7): → ABORT.
  - Every non-EXEC op drives we_out=0.
- Watchdog: step count increments every RUN cycle. When it reaches MAX_STEPS in a non-HALT cycle, go to ABORT; watchdog priority is below HALT. That cycle's instruction still executes, including its write, but the pc update is discarded.
- DONE: done_out=1, then → IDLE.
- ABORT: done_out=1 and err_out=1, then → IDLE.
- Idle controls apply in IDLE, DONE and ABORT, and after reset: we=0, rsel=asel=bsel=R0, dsel=ALU, fsel=MOVA.
- pc arithmetic: unsigned UPC_W-bit; 2^UPC_W-1 + 1 wraps to 0.
- start_in is ignored outside IDLE.
- srst in any state: next cycle IDLE, pc=START_ADDR, count=0, flags=0, all pulse outputs 0.

## Timing
- Control outputs are combinational from state and instr_in. pc, flags, count and state are registered.
- start_in high at cycle t → first instruction's controls at t+1.
- EXEC costs 1 cycle. JMP and taken or untaken branches cost 1 cycle.
- BZ/BN test flags from the most recent EXEC, not the same-cycle z_in.
- HALT at cycle k → done_out at k+1, busy_out low at k+2. start_in at k+2 is accepted.
- Back-to-back programs: minimum 2 cycles between HALT and the next first instruction.

## Structure
- Add to fsmd_pkg:
  - UPC_W = 5.
  - uop_t enum {EXEC, JMP, BZ, BN, HALT}.
  - uinstr_t packed struct {op, target[UPC_W], we, rsel, asel, bsel, dsel, fsel}.
  - Reuse the existing rsel_t, dsel_t and alufunc_t.
- Single module, no sub-modules.
- The bench provides fsmd_urom: a combinational case-ROM indexed by pc_out. It is not part of the RTL deliverable.

## Test plan
- Straight-line program: INC R0; EXT→R1; EXT→R2; ADD R4=R1+R2; HALT, with ext=3 then 4 → R4=7. done_out pulses exactly once, 6 cycles after start.
- BZ taken and not taken:
  - AND R6=R5&R0 giving 0 → BZ jumps to target (pc_out=target next cycle).
  - Result nonzero → pc_out=pc+1.
  - We_out=0 during the branch cycle.
- Count-down loop: R1=5, DEC-by-ADD of −1, BN exit. Loop body executes 6 times; final R1=−1.
- Watchdog: MAX_STEPS=8 with program "0: JMP 0" → done_out=err_out=1 on cycle 9 after start; no register writes.
- Reserved op 6 at pc 2 → ABORT with err_out pulse. Reset asserted mid-RUN → next cycle busy_out=0, pc_out=START_ADDR, we_out=0.
- start_in held high during RUN is ignored. After DONE it relaunches; pc wraps from 31 to 0 on EXEC.

Source files
------------

// File: rtl/fsmd_pkg.sv
// Shared types for the FSMD datapath and its microcoded sequencer.
package fsmd_pkg;

   localparam int unsigned UPC_W  = 5;
   localparam int unsigned STEP_W = 16;

   typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} rsel_t;

   typedef enum logic {DSEL_ALU, DSEL_EXT} dsel_t;

   typedef enum logic [2:0] {
      ALU_MOVA, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_MOVB
   } alufunc_t;

   // Codes 5..7 are reserved and abort the program.
   typedef enum logic [2:0] {EXEC, JMP, BZ, BN, HALT} uop_t;

   typedef struct packed {
      uop_t             op;
      logic [UPC_W-1:0] target;
      logic             we;
      rsel_t            rsel;
      rsel_t            asel;
      rsel_t            bsel;
      dsel_t            dsel;
      alufunc_t         fsel;
   } uinstr_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ABORT} seq_state_t;

endpackage

// File: rtl/fsmd_seq.sv
// Microcoded sequencer: steps a pc through an external micro-ROM, decodes
// datapath controls, branches on latched ALU flags, and aborts runaways.
module fsmd_seq
   import fsmd_pkg::*;
#(
   parameter logic [UPC_W-1:0] START_ADDR = '0,
   parameter int unsigned      MAX_STEPS  = 255
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             start_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             err_out,
   output logic [UPC_W-1:0] pc_out,
   input  uinstr_t          instr_in,
   input  logic             n_in,
   input  logic             z_in,
   output logic             we_out,
   output rsel_t            rsel_out,
   output rsel_t            asel_out,
   output rsel_t            bsel_out,
   output dsel_t            dsel_out,
   output alufunc_t         fsel_out
);

   seq_state_t        state_q, state_d;
   logic [UPC_W-1:0]  pc_q, pc_d, pc_inc;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic              n_q, n_d, z_q, z_d;
   logic              wd_hit;

   // State, pc, step count and branch flags
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_IDLE;
         pc_q    <= START_ADDR;
         cnt_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      z_d      = z_q;
      we_out   = 1'b0;
      rsel_out = R0;
      asel_out = R0;
      bsel_out = R0;
      dsel_out = DSEL_ALU;
      fsel_out = ALU_MOVA;
      done_out = 1'b0;
      err_out  = 1'b0;
      pc_inc   = pc_q + UPC_W'(1);
      // The count after this cycle reaching the limit means this is the last allowed step
      wd_hit   = (cnt_q + STEP_W'(1)) == STEP_W'(MAX_STEPS);

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = S_RUN;
               pc_d    = START_ADDR;
               cnt_d   = '0;
               n_d     = 1'b0;
               z_d     = 1'b0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + STEP_W'(1);
            case (instr_in.op)
               EXEC: begin
                  we_out   = instr_in.we;
                  rsel_out = instr_in.rsel;
                  asel_out = instr_in.asel;
                  bsel_out = instr_in.bsel;
                  dsel_out = instr_in.dsel;
                  fsel_out = instr_in.fsel;
                  n_d      = n_in;
                  z_d      = z_in;
                  pc_d     = pc_inc;
               end
               JMP:     pc_d = instr_in.target;
               BZ:      pc_d = z_q ? instr_in.target : pc_inc;
               BN:      pc_d = n_q ? instr_in.target : pc_inc;
               HALT:    state_d = S_DONE;
               default: state_d = S_ABORT;
            endcase
            // Watchdog yields to HALT; the instruction still executes but pc is frozen
            if (wd_hit && (instr_in.op != HALT)) begin
               state_d = S_ABORT;
               pc_d    = pc_q;
            end
         end
         S_DONE: begin
            done_out = 1'b1;
            state_d  = S_IDLE;
         end
         S_ABORT: begin
            done_out = 1'b1;
            err_out  = 1'b1;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign busy_out = (state_q != S_IDLE);
   assign pc_out   = pc_q;

endmodule

// File: tb/tb_fsmd_seq.sv
// Bench for fsmd_seq: micro-ROM and 8-bit datapath model, decode vector table,
// directed corner programs and random programs checked against an ISA-level model.
`timescale 1ns/1ps
module tb_fsmd_seq;
   import fsmd_pkg::*;

   localparam int unsigned      MAXS  = 24;
   localparam int unsigned      ROM_N = 1 << UPC_W;
   localparam logic [UPC_W-1:0] START = '0;

   logic             clk = 1'b0;
   logic             srst, start_i;
   logic             busy, done, err, we, n, z;
   logic [UPC_W-1:0] pc;
   uinstr_t          instr;
   rsel_t            rsel, asel, bsel;
   dsel_t            dsel;
   alufunc_t         fsel;

   uinstr_t    rom     [ROM_N];
   logic [7:0] ext_tab [ROM_N];
   logic [7:0] rf      [8];
   logic [7:0] alu_v, wdata;

   int n_cmp = 0;
   int n_bad = 0;

   fsmd_seq #(.START_ADDR(START), .MAX_STEPS(MAXS)) dut (
      .clk(clk), .srst(srst), .start_in(start_i), .busy_out(busy), .done_out(done),
      .err_out(err), .pc_out(pc), .instr_in(instr), .n_in(n), .z_in(z), .we_out(we),
      .rsel_out(rsel), .asel_out(asel), .bsel_out(bsel), .dsel_out(dsel), .fsel_out(fsel)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu(input alufunc_t f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_INC:  return a + 8'd1;
         ALU_MOVB: return b;
         default:  return a;
      endcase
   endfunction

   // Micro-ROM and datapath
   assign instr = rom[pc];
   always_comb begin
      alu_v = alu(fsel, rf[asel], rf[bsel]);
      wdata = (dsel == DSEL_EXT) ? ext_tab[pc] : alu_v;
   end
   assign n = alu_v[7];
   assign z = (alu_v == 8'd0);

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (we) begin
         rf[rsel] <= wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic uinstr_t ex(input logic w, input rsel_t rd, input rsel_t ra, input rsel_t rb,
                                  input dsel_t d, input alufunc_t f);
      uinstr_t i;
      i      = '0;
      i.op   = EXEC;
      i.we   = w;
      i.rsel = rd;
      i.asel = ra;
      i.bsel = rb;
      i.dsel = d;
      i.fsel = f;
      return i;
   endfunction

   function automatic uinstr_t br(input uop_t op, input logic [UPC_W-1:0] t);
      uinstr_t i;
      i        = '0;
      i.op     = op;
      i.target = t;
      return i;
   endfunction

   function automatic uinstr_t rsv(input logic [2:0] code);
      logic [$bits(uinstr_t)-1:0] v;
      v = '0;
      v[$bits(uinstr_t)-1 -: 3] = code;
      return uinstr_t'(v);
   endfunction

   task automatic fill_halt();
      for (int a = 0; a < ROM_N; a++) rom[a] = br(HALT, '0);
   endtask

   // Instruction-level reference: runs the whole program from the current register file
   logic [UPC_W-1:0] exp_pc [$];
   bit               exp_we [$];
   bit               exp_err;
   logic [7:0]       exp_rf [8];

   function automatic void ref_run();
      logic [UPC_W-1:0] p;
      int               steps;
      bit               fn, fz;
      uinstr_t          i;
      logic [7:0]       res;
      p = START; steps = 0; fn = 1'b0; fz = 1'b0;
      exp_pc.delete();
      exp_we.delete();
      exp_err = 1'b0;
      for (int k = 0; k < 8; k++) exp_rf[k] = rf[k];
      while (1) begin
         i = rom[p];
         steps++;
         exp_pc.push_back(p);
         exp_we.push_back(i.op == EXEC && i.we);
         if (i.op == HALT) break;
         if (i.op == EXEC) begin
            res = alu(i.fsel, exp_rf[i.asel], exp_rf[i.bsel]);
            fn  = res[7];
            fz  = (res == 8'd0);
            if (i.we) exp_rf[i.rsel] = (i.dsel == DSEL_EXT) ? ext_tab[p] : res;
            p = p + UPC_W'(1);
         end else if (i.op == JMP) begin
            p = i.target;
         end else if (i.op == BZ) begin
            p = fz ? i.target : p + UPC_W'(1);
         end else if (i.op == BN) begin
            p = fn ? i.target : p + UPC_W'(1);
         end else begin
            exp_err = 1'b1;
            break;
         end
         if (steps == MAXS) begin
            exp_err = 1'b1;
            break;
         end
      end
   endfunction

   // Launch at the current falling edge; hold keeps start_in high through the run.
   task automatic run_prog(input string tag, input bit hold);
      int steps;
      ref_run();
      steps   = exp_pc.size();
      start_i = 1'b1;
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      for (int s = 0; s < steps; s++) begin
         check({tag, " busy"}, 32'(busy), 32'(1));
         check({tag, " pc"},   32'(pc),   32'(exp_pc[s]));
         check({tag, " we"},   32'(we),   32'(exp_we[s]));
         check({tag, " done early"}, 32'(done), 32'(0));
         @(negedge clk);
      end
      start_i = 1'b0;
      check({tag, " done"}, 32'(done), 32'(1));
      check({tag, " err"},  32'(err),  32'(exp_err));
      @(negedge clk);
      check({tag, " idle busy"}, 32'(busy), 32'(0));
      check({tag, " idle done"}, 32'(done), 32'(0));
      for (int k = 0; k < 8; k++) check({tag, " rf"}, 32'(rf[k]), 32'(exp_rf[k]));
   endtask

   typedef struct {
      uinstr_t          ins;
      logic             exp_we;
      logic [UPC_W-1:0] exp_next;
      logic             exp_done;
      logic             exp_err;
   } vec_t;

   vec_t vt [8];

   initial begin
      srst    = 1'b1;
      start_i = 1'b0;
      fill_halt();
      for (int a = 0; a < ROM_N; a++) ext_tab[a] = 8'($urandom);

      vt[0] = '{ex(1'b1, R3, R5, R6, DSEL_EXT, ALU_XOR), 1'b1, UPC_W'(1),  1'b0, 1'b0};
      vt[1] = '{ex(1'b0, R7, R1, R2, DSEL_ALU, ALU_ADD), 1'b0, UPC_W'(1),  1'b0, 1'b0};
      vt[2] = '{br(JMP, UPC_W'(17)),                     1'b0, UPC_W'(17), 1'b0, 1'b0};
      vt[3] = '{br(BZ, UPC_W'(9)),                       1'b0, UPC_W'(1),  1'b0, 1'b0};
      vt[4] = '{br(BN, UPC_W'(9)),                       1'b0, UPC_W'(1),  1'b0, 1'b0};
      vt[5] = '{br(HALT, UPC_W'(3)),                     1'b0, UPC_W'(0),  1'b1, 1'b0};
      vt[6] = '{rsv(3'd5),                               1'b0, UPC_W'(0),  1'b1, 1'b1};
      vt[7] = '{rsv(3'd7),                               1'b0, UPC_W'(0),  1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'(0));
      check("reset pc",   32'(pc),   32'(START));
      check("reset we",   32'(we),   32'(0));
      check("reset done", 32'(done), 32'(0));
      check("reset err",  32'(err),  32'(0));
      check("reset rsel", 32'(rsel), 32'(R0));
      check("reset dsel", 32'(dsel), 32'(DSEL_ALU));
      check("reset fsel", 32'(fsel), 32'(ALU_MOVA));
      srst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle hold busy", 32'(busy), 32'(0));

      // Single-instruction decode table, each closed by a reset
      for (int v = 0; v < 8; v++) begin
         fill_halt();
         rom[0]  = vt[v].ins;
         start_i = 1'b1;
         @(negedge clk);
         start_i = 1'b0;
         check("vec pc0",  32'(pc),   32'(START));
         check("vec we",   32'(we),   32'(vt[v].exp_we));
         check("vec done0", 32'(done), 32'(0));
         if (vt[v].ins.op == EXEC) begin
            check("vec rsel", 32'(rsel), 32'(vt[v].ins.rsel));
            check("vec asel", 32'(asel), 32'(vt[v].ins.asel));
            check("vec bsel", 32'(bsel), 32'(vt[v].ins.bsel));
            check("vec dsel", 32'(dsel), 32'(vt[v].ins.dsel));
            check("vec fsel", 32'(fsel), 32'(vt[v].ins.fsel));
         end
         @(negedge clk);
         check("vec done", 32'(done), 32'(vt[v].exp_done));
         check("vec err",  32'(err),  32'(vt[v].exp_err));
         if (!vt[v].exp_done) begin
            check("vec next pc", 32'(pc),   32'(vt[v].exp_next));
            check("vec busy",    32'(busy), 32'(1));
         end
         srst = 1'b1;
         @(negedge clk);
         srst = 1'b0;
         check("srst busy", 32'(busy), 32'(0));
         check("srst pc",   32'(pc),   32'(START));
         check("srst we",   32'(we),   32'(0));
         check("srst done", 32'(done), 32'(0));
      end

      // Straight-line: INC R0; EXT->R1; EXT->R2; R4=R1+R2; HALT
      fill_halt();
      ext_tab[1] = 8'd3;
      ext_tab[2] = 8'd4;
      rom[0] = ex(1'b1, R0, R0, R0, DSEL_ALU, ALU_INC);
      rom[1] = ex(1'b1, R1, R0, R0, DSEL_EXT, ALU_MOVA);
      rom[2] = ex(1'b1, R2, R0, R0, DSEL_EXT, ALU_MOVA);
      rom[3] = ex(1'b1, R4, R1, R2, DSEL_ALU, ALU_ADD);
      run_prog("straight", 1'b0);
      check("straight R4", 32'(rf[4]), 32'(7));

      // BZ taken (R5&R0 == 0), then BZ untaken (R1&R0 != 0)
      fill_halt();
      rom[0] = ex(1'b1, R6, R5, R0, DSEL_ALU, ALU_AND);
      rom[1] = br(BZ, UPC_W'(6));
      rom[6] = ex(1'b1, R6, R1, R0, DSEL_ALU, ALU_AND);
      rom[7] = br(BZ, UPC_W'(20));
      run_prog("bz", 1'b0);
      check("bz R6", 32'(rf[6]), 32'(1));

      // Count-down loop: R1=5, R1+=-1 until negative
      fill_halt();
      ext_tab[0] = 8'hFF;
      ext_tab[1] = 8'd5;
      rom[0] = ex(1'b1, R7, R0, R0, DSEL_EXT, ALU_MOVA);
      rom[1] = ex(1'b1, R1, R0, R0, DSEL_EXT, ALU_MOVA);
      rom[2] = ex(1'b1, R1, R1, R7, DSEL_ALU, ALU_ADD);
      rom[3] = br(BN, UPC_W'(5));
      rom[4] = br(JMP, UPC_W'(2));
      run_prog("loop", 1'b0);
      check("loop R1", 32'(rf[1]), 32'(8'hFF));

      // Watchdog on a tight JMP loop
      fill_halt();
      rom[0] = br(JMP, UPC_W'(0));
      run_prog("wd jmp", 1'b0);

      // HALT landing exactly on the last allowed step wins over the watchdog
      fill_halt();
      for (int a = 0; a < MAXS - 1; a++) rom[a] = ex(1'b1, R3, R3, R0, DSEL_ALU, ALU_INC);
      run_prog("wd halt", 1'b0);

      // One more EXEC: the final step still writes, then aborts
      fill_halt();
      for (int a = 0; a < MAXS; a++) rom[a] = ex(1'b1, R3, R3, R0, DSEL_ALU, ALU_INC);
      run_prog("wd exec", 1'b0);

      // Reserved op 6 at pc 2
      fill_halt();
      rom[0] = ex(1'b1, R2, R2, R0, DSEL_ALU, ALU_INC);
      rom[1] = ex(1'b0, R0, R7, R0, DSEL_ALU, ALU_MOVA);
      rom[2] = rsv(3'd6);
      run_prog("rsv", 1'b0);

      // pc wrap 31->0 with start held, then immediate relaunch
      fill_halt();
      rom[0]  = br(BN, UPC_W'(2));
      rom[1]  = br(JMP, UPC_W'(30));
      rom[30] = ex(1'b0, R0, R7, R0, DSEL_ALU, ALU_MOVA);
      rom[31] = ex(1'b1, R2, R7, R0, DSEL_ALU, ALU_MOVA);
      run_prog("wrap held", 1'b1);
      run_prog("relaunch", 1'b0);

      // Random programs
      for (int p = 0; p < 40; p++) begin
         int unsigned      r;
         logic [UPC_W-1:0] t;
         for (int a = 0; a < ROM_N; a++) begin
            r = $urandom_range(99);
            t = UPC_W'($urandom);
            if (r < 60)
               rom[a] = ex(1'($urandom), rsel_t'(3'($urandom)), rsel_t'(3'($urandom)),
                           rsel_t'(3'($urandom)), dsel_t'(1'($urandom)), alufunc_t'(3'($urandom)));
            else if (r < 70) rom[a] = br(JMP, t);
            else if (r < 80) rom[a] = br(BZ, t);
            else if (r < 90) rom[a] = br(BN, t);
            else if (r < 97) rom[a] = br(HALT, t);
            else             rom[a] = rsv(3'($urandom_range(7, 5)));
            ext_tab[a] = 8'($urandom);
         end
         run_prog("rand", 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
